// File: rtl/flag_branch_if.sv
// Signal bundle between the ALU/decode side and the flag/branch unit.
// master drives ALU flags and flow ops; slave is the unit itself.
interface flag_branch_if #(
  parameter int ADDR_W = 20
);
  logic              flag_we;
  logic [2:0]        flag_mask;
  logic              alu_sign;
  logic              alu_zero;
  logic              alu_carry;
  logic              op_valid;
  logic              op_ready;
  logic [2:0]        op_code;
  logic [ADDR_W-1:0] op_target;
  logic [2:0]        op_data;
  logic              pc_redirect;
  logic [ADDR_W-1:0] pc_target;
  logic [2:0]        status;
  logic              trap;
  logic              trap_clear;

  modport master (
    output flag_we, flag_mask, alu_sign, alu_zero, alu_carry,
    output op_valid, op_code, op_target, op_data, trap_clear,
    input  op_ready, pc_redirect, pc_target, status, trap
  );

  modport slave (
    input  flag_we, flag_mask, alu_sign, alu_zero, alu_carry,
    input  op_valid, op_code, op_target, op_data, trap_clear,
    output op_ready, pc_redirect, pc_target, status, trap
  );
endinterface

// File: rtl/flag_branch_unit.sv
// Status register {sign,zero,carry} owner and flow-control unit: conditional
// jumps with PC redirect + flush window, status load/xor, and a TRAP hold state.
module flag_branch_unit #(
  parameter int ADDR_W       = 20,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  flag_branch_if.slave bus
);

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_TRAP} state_t;
  typedef enum logic [2:0] {
    OP_NOP, OP_JU, OP_JZ, OP_JS, OP_JZS, OP_LSR, OP_XSR, OP_TRAP
  } op_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        status_q;
  logic              redirect_q;
  logic [ADDR_W-1:0] target_q;
  logic              ready;
  logic              in_trap;

  op_t        op;
  logic [2:0] alu_flags;
  logic [2:0] fwd;
  logic       accept;
  logic       taken;
  logic       jump_go;

  assign op        = op_t'(bus.op_code);
  assign alu_flags = {bus.alu_sign, bus.alu_zero, bus.alu_carry};
  // Same-cycle ALU results are visible to jumps and XSR without a bubble.
  assign fwd       = bus.flag_we ? ((status_q & ~bus.flag_mask) | (alu_flags & bus.flag_mask))
                                 : status_q;
  assign accept    = bus.op_valid & ready;
  assign jump_go   = accept & taken;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    taken = 1'b0;
    unique case (op)
      OP_JU:   taken = 1'b1;
      OP_JZ:   taken = fwd[1];
      OP_JS:   taken = fwd[2];
      OP_JZS:  taken = fwd[1] | fwd[2];
      default: taken = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (jump_go)                      state_nxt = S_FLUSH;
        else if (accept && op == OP_TRAP) state_nxt = S_TRAP;
      end
      S_FLUSH: if (cnt == '0)      state_nxt = S_IDLE;
      S_TRAP:  if (bus.trap_clear) state_nxt = S_IDLE;
      default:                     state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ready   = (state == S_IDLE);
    in_trap = (state == S_TRAP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             cnt <= '0;
    else if (jump_go)                       cnt <= CNT_W'(FLUSH_CYCLES - 1);
    else if (state == S_FLUSH && cnt != '0) cnt <= cnt - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_q <= 1'b0;
      target_q   <= '0;
    end else begin
      redirect_q <= jump_go;
      if (jump_go) target_q <= bus.op_target;
    end
  end

  // LSR beats a same-cycle ALU write; TRAP freezes the register entirely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        status_q <= '0;
    else if (state != S_TRAP) begin
      if (accept && op == OP_LSR)      status_q <= bus.op_data;
      else if (accept && op == OP_XSR) status_q <= fwd ^ bus.op_data;
      else if (bus.flag_we)            status_q <= fwd;
    end
  end

  assign bus.op_ready    = ready;
  assign bus.trap        = in_trap;
  assign bus.status      = status_q;
  assign bus.pc_redirect = redirect_q;
  assign bus.pc_target   = target_q;

endmodule

// File: tb/tb_flag_branch_unit.sv
// Bench for flag_branch_unit: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a transaction-level model.
module tb_flag_branch_unit;

  localparam int ADDR_W = 20;
  localparam int FLUSH  = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  flag_branch_if #(.ADDR_W(ADDR_W)) bus ();

  flag_branch_unit #(.ADDR_W(ADDR_W), .FLUSH_CYCLES(FLUSH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: busy counts the remaining not-ready cycles after a taken jump.
  typedef struct packed {
    logic [2:0]        status;
    logic              in_trap;
    int                busy;
    logic              redirect;
    logic [ADDR_W-1:0] target;
  } model_t;

  localparam model_t RESET_M = '{status: 3'b000, in_trap: 1'b0, busy: 0,
                                 redirect: 1'b0, target: '0};
  model_t m;

  function automatic model_t model_step(model_t cur);
    model_t     n     = cur;
    logic [2:0] alu   = {bus.alu_sign, bus.alu_zero, bus.alu_carry};
    logic [2:0] fwd   = cur.status;
    logic       rdy   = (cur.busy == 0) && !cur.in_trap;
    logic       taken = 1'b0;
    for (int i = 0; i < 3; i++)
      if (bus.flag_we && bus.flag_mask[i]) fwd[i] = alu[i];
    n.redirect = 1'b0;
    n.busy     = (cur.busy > 0) ? cur.busy - 1 : 0;
    if (cur.in_trap) begin
      if (bus.trap_clear) n.in_trap = 1'b0;
      return n;
    end
    if (bus.flag_we) n.status = fwd;
    if (bus.op_valid && rdy) begin
      case (bus.op_code)
        3'd1: taken = 1'b1;
        3'd2: taken = fwd[1];
        3'd3: taken = fwd[2];
        3'd4: taken = fwd[1] | fwd[2];
        3'd5: n.status = bus.op_data;
        3'd6: n.status = fwd ^ bus.op_data;
        3'd7: n.in_trap = 1'b1;
        default: ;
      endcase
    end
    if (taken) begin
      n.redirect = 1'b1;
      n.target   = bus.op_target;
      n.busy     = FLUSH;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= RESET_M;
    else        m <= model_step(m);
  end

  always @(negedge clk) begin
    check("status",      {29'd0, bus.status},        {29'd0, m.status});
    check("op_ready",    {31'd0, bus.op_ready},      {31'd0, (m.busy == 0) && !m.in_trap});
    check("trap",        {31'd0, bus.trap},          {31'd0, m.in_trap});
    check("pc_redirect", {31'd0, bus.pc_redirect},   {31'd0, m.redirect});
    check("pc_target",   {12'd0, bus.pc_target},     {12'd0, m.target});
  end

  task automatic idle_inputs();
    bus.flag_we    = 1'b0;
    bus.flag_mask  = 3'b000;
    bus.alu_sign   = 1'b0;
    bus.alu_zero   = 1'b0;
    bus.alu_carry  = 1'b0;
    bus.op_valid   = 1'b0;
    bus.op_code    = 3'd0;
    bus.op_target  = '0;
    bus.op_data    = 3'b000;
    bus.trap_clear = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic alu_write(input logic [2:0] mask, input logic [2:0] flags);
    bus.flag_we   = 1'b1;
    bus.flag_mask = mask;
    {bus.alu_sign, bus.alu_zero, bus.alu_carry} = flags;
  endtask

  task automatic issue(input logic [2:0] code, input logic [ADDR_W-1:0] tgt, input logic [2:0] data);
    bus.op_valid  = 1'b1;
    bus.op_code   = code;
    bus.op_target = tgt;
    bus.op_data   = data;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    #12;
    check("rst_status",   {29'd0, bus.status},      32'd0);
    check("rst_ready",    {31'd0, bus.op_ready},    32'd1);
    check("rst_trap",     {31'd0, bus.trap},        32'd0);
    check("rst_redirect", {31'd0, bus.pc_redirect}, 32'd0);
    rst_n = 1'b1;
    repeat (3) step();
    check("idle_status", {29'd0, bus.status},   32'd0);
    check("idle_ready",  {31'd0, bus.op_ready}, 32'd1);

    // JZ taken via forwarded zero flag
    alu_write(3'b111, 3'b010);
    issue(3'd2, 20'h0ABCD, 3'b000);
    step();
    idle_inputs();
    check("jz_redirect", {31'd0, bus.pc_redirect}, 32'd1);
    check("jz_target",   {12'd0, bus.pc_target},   32'h0ABCD);
    check("jz_ready0",   {31'd0, bus.op_ready},    32'd0);
    check("jz_status",   {29'd0, bus.status},      32'b010);
    step();
    check("jz_pulse_end", {31'd0, bus.pc_redirect}, 32'd0);
    check("jz_ready1",    {31'd0, bus.op_ready},    32'd0);
    step();
    check("jz_ready2",    {31'd0, bus.op_ready},    32'd1);

    // JS not taken with clear status
    alu_write(3'b111, 3'b000);
    step();
    idle_inputs();
    issue(3'd3, 20'h00010, 3'b000);
    step();
    idle_inputs();
    check("js_redirect", {31'd0, bus.pc_redirect}, 32'd0);
    check("js_ready",    {31'd0, bus.op_ready},    32'd1);
    check("js_status",   {29'd0, bus.status},      32'd0);
    check("js_target",   {12'd0, bus.pc_target},   32'h0ABCD);

    // LSR overrides same-cycle ALU write, then XSR
    alu_write(3'b111, 3'b010);
    issue(3'd5, '0, 3'b101);
    step();
    idle_inputs();
    check("lsr_status", {29'd0, bus.status}, 32'b101);
    issue(3'd6, '0, 3'b111);
    step();
    idle_inputs();
    check("xsr_status", {29'd0, bus.status}, 32'b010);

    // TRAP freezes status until cleared
    issue(3'd7, '0, 3'b000);
    step();
    idle_inputs();
    check("trap_on",    {31'd0, bus.trap},     32'd1);
    check("trap_ready", {31'd0, bus.op_ready}, 32'd0);
    alu_write(3'b111, 3'b111);
    step();
    idle_inputs();
    check("trap_frozen", {29'd0, bus.status}, 32'b010);
    bus.trap_clear = 1'b1;
    step();
    idle_inputs();
    check("trap_off",       {31'd0, bus.trap},     32'd0);
    check("trap_ready_back", {31'd0, bus.op_ready}, 32'd1);

    // Async reset in the middle of a flush
    issue(3'd1, 20'h12345, 3'b000);
    step();
    idle_inputs();
    check("ju_redirect", {31'd0, bus.pc_redirect}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rstf_redirect", {31'd0, bus.pc_redirect}, 32'd0);
    check("rstf_target",   {12'd0, bus.pc_target},   32'd0);
    check("rstf_ready",    {31'd0, bus.op_ready},    32'd1);
    #1 rst_n = 1'b1;
    step();

    // Randomized traffic, occasional async reset
    for (int i = 0; i < 3000; i++) begin
      bus.flag_we    = ($urandom_range(0, 1) == 1);
      bus.flag_mask  = 3'($urandom);
      bus.alu_sign   = 1'($urandom);
      bus.alu_zero   = 1'($urandom);
      bus.alu_carry  = 1'($urandom);
      bus.op_valid   = ($urandom_range(0, 2) != 0);
      bus.op_code    = 3'($urandom);
      bus.op_target  = ADDR_W'($urandom);
      bus.op_data    = 3'($urandom);
      bus.trap_clear = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
      end
      step();
    end
    idle_inputs();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
